shift_pass_sequencer: RTL and testbench

Multi-pass shift/rotate engine that sits directly upstream of the team's 4-bit combinational shift datapath. It accepts a shift command whose amount may exceed the datapath's per-pass range (0..3). It then executes the command as a sequence of single-cycle passes, each bounded by that range, and presents the registered result on a valid/ready output. Commands enter through a valid/ready handshake, and one command is in flight at a time.

---
 rtl/shift_seq_pkg.sv | 26 ++
 rtl/shift_pass.sv | 34 +++
 rtl/shift_pass_sequencer.sv | 144 ++++++++++++++
 tb/tb_shift_pass_sequencer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-pass shift sequencer.
package shift_seq_pkg;

    localparam int unsigned SEQ_WIDTH  = 4;
    localparam int unsigned SEQ_PASS_W = 2;
    localparam int unsigned SEQ_AMT_W  = 4;

    localparam logic DIR_LEFT   = 1'b0;
    localparam logic DIR_RIGHT  = 1'b1;
    localparam logic MODE_LOGIC = 1'b0;
    localparam logic MODE_ROT   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Largest shift a single datapath pass can apply.
    function automatic int unsigned step_max(input int unsigned pass_w);
        return (32'd1 << pass_w) - 32'd1;
    endfunction

    localparam int unsigned STEP_MAX = step_max(SEQ_PASS_W);

endpackage

// File: rtl/shift_pass.sv
// Single combinational shift/rotate pass bounded to the per-pass range.
module shift_pass
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = SEQ_WIDTH,
    parameter int unsigned PASS_W = SEQ_PASS_W
) (
    input  logic [WIDTH-1:0]  data_i,
    input  logic [PASS_W-1:0] amt_i,
    input  logic              dir_i,
    input  logic              rot_i,
    output logic [WIDTH-1:0]  result_c
);

    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] wrap_l;
    logic [WIDTH-1:0] wrap_r;

    // Wrap terms supply the bits a rotate brings back in; a shift by WIDTH yields 0.
    always_comb begin
        shl    = data_i << amt_i;
        shr    = data_i >> amt_i;
        wrap_l = data_i >> (WIDTH - 32'(amt_i));
        wrap_r = data_i << (WIDTH - 32'(amt_i));
        result_c = '0;
        if (dir_i == DIR_LEFT) begin
            result_c = (rot_i == MODE_ROT) ? (shl | wrap_l) : shl;
        end else begin
            result_c = (rot_i == MODE_ROT) ? (shr | wrap_r) : shr;
        end
    end

endmodule

// File: rtl/shift_pass_sequencer.sv
// Breaks a wide shift command into bounded single-cycle passes and
// presents the registered result on a valid/ready output.
module shift_pass_sequencer
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = SEQ_WIDTH,
    parameter int unsigned PASS_W = SEQ_PASS_W,
    parameter int unsigned AMT_W  = SEQ_AMT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    input  logic             in_rot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AMT_W-1:0] out_passes,
    output logic             busy
);

    localparam int unsigned STEP_LIM = step_max(PASS_W);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [AMT_W-1:0] passes_q, passes_d;
    logic             dir_q, dir_d;
    logic             rot_q, rot_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [AMT_W-1:0] out_passes_q, out_passes_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    logic [PASS_W-1:0] step_c;
    logic [AMT_W-1:0]  rem_next_c;
    logic [WIDTH-1:0]  pass_data_c;

    assign step_c     = (rem_q > AMT_W'(STEP_LIM)) ? PASS_W'(STEP_LIM) : PASS_W'(rem_q);
    assign rem_next_c = rem_q - AMT_W'(step_c);

    shift_pass #(
        .WIDTH  (WIDTH),
        .PASS_W (PASS_W)
    ) u_pass (
        .data_i   (data_q),
        .amt_i    (step_c),
        .dir_i    (dir_q),
        .rot_i    (rot_q),
        .result_c (pass_data_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            data_q       <= '0;
            rem_q        <= '0;
            passes_q     <= '0;
            dir_q        <= 1'b0;
            rot_q        <= 1'b0;
            out_data_q   <= '0;
            out_passes_q <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            rem_q        <= rem_d;
            passes_q     <= passes_d;
            dir_q        <= dir_d;
            rot_q        <= rot_d;
            out_data_q   <= out_data_d;
            out_passes_q <= out_passes_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
        end
    end

    // Result registers load only on entry to DONE so they hold elsewhere.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        rem_d        = rem_q;
        passes_d     = passes_q;
        dir_d        = dir_q;
        rot_d        = rot_q;
        out_data_d   = out_data_q;
        out_passes_d = out_passes_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d   = in_data;
                    dir_d    = in_dir;
                    rot_d    = in_rot;
                    rem_d    = in_amt;
                    passes_d = '0;
                    if (in_amt == '0) begin
                        state_d      = DONE;
                        out_data_d   = in_data;
                        out_passes_d = '0;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                data_d   = pass_data_c;
                rem_d    = rem_next_c;
                passes_d = passes_q + AMT_W'(1);
                if (rem_next_c == '0) begin
                    state_d      = DONE;
                    out_data_d   = pass_data_c;
                    out_passes_d = passes_q + AMT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_passes = out_passes_q;

endmodule

// File: tb/tb_shift_pass_sequencer.sv
// Directed bench for shift_pass_sequencer with hand-computed expectations.
module tb_shift_pass_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [3:0] in_amt;
    logic       in_dir;
    logic       in_rot;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [3:0] out_passes;
    logic       busy;

    int n_checks;
    int n_fail;

    shift_pass_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .in_dir     (in_dir),
        .in_rot     (in_rot),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_passes (out_passes),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, wait (bounded) for the result, check it, then handshake.
    task automatic run_cmd(input string tag, input logic [3:0] d, input logic [3:0] amt,
                           input logic dir, input logic rot,
                           input logic [3:0] exp_data, input logic [3:0] exp_passes);
        int lat;
        in_data  = d;
        in_amt   = amt;
        in_dir   = dir;
        in_rot   = rot;
        in_valid = 1'b1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_passes));
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".data"}, 32'(out_data), 32'(exp_data));
        check({tag, ".passes"}, 32'(out_passes), 32'(exp_passes));
        check({tag, ".busy"}, 32'(busy), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_dir    = 1'b0;
        in_rot    = 1'b0;
        out_ready = 1'b0;

        #12;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.out_data", 32'(out_data), 32'd0);
        check("rst.out_passes", 32'(out_passes), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_cmd("lsl5",  4'b1011, 4'd5, 1'b0, 1'b0, 4'b0000, 4'd2);
        run_cmd("ror7",  4'b1001, 4'd7, 1'b1, 1'b1, 4'b0011, 4'd3);
        run_cmd("lsr2",  4'b1100, 4'd2, 1'b1, 1'b0, 4'b0011, 4'd1);
        run_cmd("zero",  4'b0110, 4'd0, 1'b0, 1'b0, 4'b0110, 4'd0);
        run_cmd("rol6",  4'b0001, 4'd6, 1'b0, 1'b1, 4'b0100, 4'd2);
        run_cmd("lsl3",  4'b0111, 4'd3, 1'b0, 1'b0, 4'b1000, 4'd1);

        // Backpressure: rotl 0101 by 1 -> 1010, while a new command waits.
        in_data = 4'b0101; in_amt = 4'd1; in_dir = 1'b0; in_rot = 1'b1; in_valid = 1'b1;
        step();
        in_data = 4'b0011; in_amt = 4'd1; in_dir = 1'b1; in_rot = 1'b1;
        step();
        check("bp.enter_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp.hold_valid", 32'(out_valid), 32'd1);
            check("bp.hold_data", 32'(out_data), 32'b1010);
            check("bp.hold_passes", 32'(out_passes), 32'd1);
            check("bp.hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp.idle_ready", 32'(in_ready), 32'd1);
        check("bp.idle_valid", 32'(out_valid), 32'd0);
        check("bp.idle_data", 32'(out_data), 32'b1010);
        step();
        in_valid = 1'b0;
        check("bp.accept_busy", 32'(busy), 32'd1);
        check("bp.accept_valid", 32'(out_valid), 32'd0);
        step();
        check("bp.new_valid", 32'(out_valid), 32'd1);
        check("bp.new_data", 32'(out_data), 32'b1001);
        check("bp.new_passes", 32'(out_passes), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset during the second pass of a 15-step command.
        in_data = 4'b1111; in_amt = 4'd15; in_dir = 1'b0; in_rot = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("rr.mid_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr.out_valid", 32'(out_valid), 32'd0);
        check("rr.busy", 32'(busy), 32'd0);
        check("rr.in_ready", 32'(in_ready), 32'd1);
        check("rr.out_passes", 32'(out_passes), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_cmd("ror15", 4'b0001, 4'd15, 1'b1, 1'b1, 4'b0010, 4'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
